// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS run/step controller: system state encoding
// and the KEY stability window used by the press filter.
package mips_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'b000;
    localparam logic [2:0] ST_LOAD      = 3'b001;
    localparam logic [2:0] ST_RUN       = 3'b010;
    localparam logic [2:0] ST_STEP_WAIT = 3'b011;
    localparam logic [2:0] ST_STEP_EXEC = 3'b100;
    localparam logic [2:0] ST_DONE      = 3'b101;
    localparam logic [2:0] ST_FAULT     = 3'b110;

    // Consecutive synchronized-low cycles that make one KEY press.
    localparam int KEY_STABLE_CYC = 4;

endpackage

// File: rtl/mips_run_controller_key_press_sync.sv
// KEY press detector: 2-FF synchronizer for the raw active-low KEY, then a
// stability filter that emits a single-cycle pulse once the synchronized
// level has been low for KEY_STABLE_CYC consecutive cycles after a high.
// Holding the KEY produces no further pulses until it is seen high again.
module key_press_sync
    import mips_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = $clog2(KEY_STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(KEY_STABLE_CYC - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_armed;
    logic             r_press;
    logic [CNT_W-1:0] r_low_cnt;

    // Two-stage synchronizer; resets to the released (high) level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
        end
    end

    // Count stable-low cycles; fire once, then wait for a high to re-arm.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed   <= 1'b1;
            r_low_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync) begin
                r_armed   <= 1'b1;
                r_low_cnt <= '0;
            end else if (r_armed) begin
                if (r_low_cnt == LP_LAST) begin
                    r_press   <= 1'b1;
                    r_armed   <= 1'b0;
                    r_low_cnt <= '0;
                end else begin
                    r_low_cnt <= r_low_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/mips_run_controller.sv
// Run/step sequencer for the MIPS core. Holds the core in reset until the
// program is loaded, then enables the pipeline continuously or one step per
// KEY press, counts enabled cycles (saturating) and stops on program finish
// or when the cycle budget is used up.
// Optional feature: define BREAKPOINT_EN to drop from RUN into STEP_WAIT
// when pc_in matches break_addr; otherwise pc_in/break_addr are ignored.
module mips_run_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 4096,
    parameter int PC_W       = 32
)
(
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             start_sw,
    input  logic             step_mode_sw,
    input  logic             step_key_n,
    input  logic             program_loaded,
    input  logic             program_finished,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  break_addr,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [2:0]       sys_state,
    output logic [CYC_W-1:0] cycle_count,
    output logic             done,
    output logic             fault
);

    localparam logic [CYC_W-1:0] LP_MAX = CYC_W'(MAX_CYCLES);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_cpu_rst;
    logic             r_cpu_en;
    logic             r_done;
    logic             r_fault;
    logic [CYC_W-1:0] r_count;
    logic [CYC_W-1:0] w_count_next;
    logic             w_press;
    logic             w_bp_hit;

    key_press_sync u_key (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_key_n (step_key_n),
        .o_press (w_press)
    );

    // Value the counter takes at this edge; the budget check looks ahead so
    // the last budgeted cycle is also the last enabled one.
    assign w_count_next = (r_cpu_en && (r_count != '1)) ? r_count + CYC_W'(1) : r_count;

`ifdef BREAKPOINT_EN
    logic r_bp_armed;

    assign w_bp_hit = r_bp_armed && r_cpu_en && (r_state == ST_RUN) && (pc_in == break_addr);

    // Breakpoint fires once per arrival at break_addr; re-arms when PC moves off it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_bp_armed <= 1'b1;
        end else if (pc_in != break_addr) begin
            r_bp_armed <= 1'b1;
        end else if (w_bp_hit) begin
            r_bp_armed <= 1'b0;
        end
    end
`else
    logic w_unused_bp;

    assign w_bp_hit    = 1'b0;
    assign w_unused_bp = ^{pc_in, break_addr};
`endif

    // Next-state selection; in the running states start_sw, finish and budget override.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_sw) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!start_sw)          w_next = ST_IDLE;
                else if (program_loaded) w_next = step_mode_sw ? ST_STEP_WAIT : ST_RUN;
            end
            ST_RUN, ST_STEP_WAIT, ST_STEP_EXEC: begin
                if (!start_sw)                   w_next = ST_IDLE;
                else if (program_finished)       w_next = ST_DONE;
                else if (w_count_next == LP_MAX) w_next = ST_FAULT;
                else begin
                    case (r_state)
                        ST_RUN: begin
                            if (w_bp_hit || step_mode_sw) w_next = ST_STEP_WAIT;
                        end
                        ST_STEP_WAIT: begin
                            if (!step_mode_sw) w_next = ST_RUN;
                            else if (w_press)  w_next = ST_STEP_EXEC;
                        end
                        default: w_next = ST_STEP_WAIT;
                    endcase
                end
            end
            ST_DONE, ST_FAULT: begin
                if (!start_sw) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state so they line up with sys_state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cpu_rst <= 1'b1;
            r_cpu_en  <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
            r_cpu_en  <= (w_next == ST_RUN) || (w_next == ST_STEP_EXEC);
            r_done    <= (w_next == ST_DONE);
            r_fault   <= (w_next == ST_FAULT);
        end
    end

    // Enabled-cycle counter: cleared while loading, saturating, frozen when disabled.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_state == ST_LOAD) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign cpu_rst     = r_cpu_rst;
    assign cpu_en      = r_cpu_en;
    assign sys_state   = r_state;
    assign cycle_count = r_count;
    assign done        = r_done;
    assign fault       = r_fault;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller (MAX_CYCLES=16). Expected values are
// hand-derived constants; a tiny PC model stands in for the core's fetch stage.
// Build with +define+BREAKPOINT_EN to exercise the breakpoint variant.
module tb_mips_run_controller;

    localparam int CYC_W = 32;
    localparam int MAXC  = 16;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start_sw;
    logic             step_mode_sw;
    logic             step_key_n;
    logic             program_loaded;
    logic             program_finished;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  break_addr;
    logic             cpu_rst;
    logic             cpu_en;
    logic [2:0]       sys_state;
    logic [CYC_W-1:0] cycle_count;
    logic             done;
    logic             fault;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mips_run_controller #(.CYC_W(CYC_W), .MAX_CYCLES(MAXC), .PC_W(PC_W)) dut (
        .CLOCK_50         (clk),
        .reset_n          (reset_n),
        .start_sw         (start_sw),
        .step_mode_sw     (step_mode_sw),
        .step_key_n       (step_key_n),
        .program_loaded   (program_loaded),
        .program_finished (program_finished),
        .pc_in            (pc),
        .break_addr       (break_addr),
        .cpu_rst          (cpu_rst),
        .cpu_en           (cpu_en),
        .sys_state        (sys_state),
        .cycle_count      (cycle_count),
        .done             (done),
        .fault            (fault)
    );

    // Core stand-in: PC clears under cpu_rst and advances 4 per enabled cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     pc <= '0;
        else if (cpu_rst) pc <= '0;
        else if (cpu_en)  pc <= pc + 32'd4;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold KEY low for 'hold' cycles, then one released cycle; counts cpu_en pulses seen.
    task automatic press_key(input int hold, output int pulses);
        pulses = 0;
        step_key_n = 1'b0;
        repeat (hold) begin
            tick();
            if (cpu_en) pulses++;
        end
        step_key_n = 1'b1;
        tick();
        if (cpu_en) pulses++;
    endtask

    initial begin
        int p;
        int total;
        int k;
        reset_n          = 1'b0;
        start_sw         = 1'b0;
        step_mode_sw     = 1'b0;
        step_key_n       = 1'b1;
        program_loaded   = 1'b0;
        program_finished = 1'b0;
        break_addr       = 32'h20;

        // 1: reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_vec("rst_state", sys_state, 3'b000);
        check_vec("rst_cpu_rst", cpu_rst, 1);
        check_vec("rst_cpu_en", cpu_en, 0);
        check_vec("rst_count", cycle_count, 0);
        check_vec("rst_done_fault", {done, fault}, 2'b00);

        // 2: load, continuous run, finish
        start_sw = 1'b1;
        tick();
        check_vec("load_state", sys_state, 3'b001);
        check_vec("load_cpu_rst", cpu_rst, 1);
        repeat (4) tick();
        check_vec("load_hold", sys_state, 3'b001);
        program_loaded = 1'b1;
        tick();
        check_vec("run_state", sys_state, 3'b010);
        check_vec("run_en_rst", {cpu_en, cpu_rst}, 2'b10);
        check_vec("run_count0", cycle_count, 0);
        repeat (5) tick();
        program_loaded = 1'b0;
        repeat (5) tick();
        check_vec("run_loaded_drop", sys_state, 3'b010);
        check_vec("run_count10", cycle_count, 10);
        program_finished = 1'b1;
        tick();
        check_vec("done_state", sys_state, 3'b101);
        check_vec("done_flag", done, 1);
        check_vec("done_en_rst", {cpu_en, cpu_rst}, 2'b00);
        check_vec("done_count", cycle_count, 11);
        repeat (3) tick();
        check_vec("done_frozen", cycle_count, 11);
        check_vec("done_hold", sys_state, 3'b101);
        start_sw = 1'b0;
        program_finished = 1'b0;
        tick();
        check_vec("done_exit", sys_state, 3'b000);
        check_vec("done_exit_flag", done, 0);

        // 3: single step, three presses with a 1-cycle release between
        step_mode_sw   = 1'b1;
        program_loaded = 1'b1;
        start_sw       = 1'b1;
        tick();
        tick();
        check_vec("step_wait", sys_state, 3'b011);
        check_vec("step_count0", cycle_count, 0);
        total = 0;
        for (int i = 0; i < 3; i++) begin
            press_key(20, p);
            total += p;
            check_vec($sformatf("step_pulses_%0d", i), total, i + 1);
        end
        repeat (10) begin
            tick();
            if (cpu_en) total++;
        end
        check_vec("step_total", total, 3);
        check_vec("step_count3", cycle_count, 3);
        check_vec("step_back_wait", sys_state, 3'b011);

        // reset in the middle of a key press
        step_key_n = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check_vec("mid_rst_state", sys_state, 3'b000);
        check_vec("mid_rst_count", cycle_count, 0);
        check_vec("mid_rst_rst_en", {cpu_rst, cpu_en}, 2'b10);
        step_key_n = 1'b1;
        start_sw   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_vec("mid_rst_idle", sys_state, 3'b000);

        // 4: watchdog
        step_mode_sw   = 1'b0;
        program_loaded = 1'b1;
        start_sw       = 1'b1;
        tick();
        tick();
        check_vec("wd_run", sys_state, 3'b010);
        k = 0;
        while (sys_state == 3'b010 && k < 40) begin
            tick();
            k++;
        end
        check_vec("wd_cycles", k, 16);
        check_vec("wd_state", sys_state, 3'b110);
        check_vec("wd_fault", fault, 1);
        check_vec("wd_cpu_en", cpu_en, 0);
        check_vec("wd_count", cycle_count, 16);
        repeat (2) tick();
        check_vec("wd_frozen", cycle_count, 16);
        start_sw = 1'b0;
        tick();
        check_vec("wd_exit", sys_state, 3'b000);
        check_vec("wd_exit_fault", fault, 0);

        // 5: finish and start_sw fall together
        start_sw = 1'b1;
        tick();
        tick();
        repeat (3) tick();
        program_finished = 1'b1;
        start_sw = 1'b0;
        tick();
        check_vec("race_state", sys_state, 3'b000);
        check_vec("race_done", done, 0);
        tick();
        check_vec("race_done2", done, 0);
        program_finished = 1'b0;

        // 6: breakpoint at 0x20
        start_sw = 1'b1;
        tick();
        tick();
        check_vec("bp_run", sys_state, 3'b010);
        repeat (9) tick();
`ifdef BREAKPOINT_EN
        check_vec("bp_state", sys_state, 3'b011);
        check_vec("bp_count", cycle_count, 9);
        check_vec("bp_pc", pc, 32'h24);
        press_key(10, p);
        check_vec("bp_step_pulses", p, 1);
        check_vec("bp_step_pc", pc, 32'h28);
        check_vec("bp_step_count", cycle_count, 10);
        step_mode_sw = 1'b0;
        tick();
        repeat (3) tick();
        check_vec("bp_no_rebreak", sys_state, 3'b010);
        check_vec("bp_count_end", cycle_count, 13);
`else
        check_vec("nobp_state", sys_state, 3'b010);
        check_vec("nobp_count", cycle_count, 9);
        repeat (3) tick();
        check_vec("nobp_stay", sys_state, 3'b010);
        check_vec("nobp_count_end", cycle_count, 12);
`endif
        start_sw = 1'b0;
        tick();
        check_vec("bp_exit", sys_state, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
